// File: rtl/sram_like_responder.sv
// Responder end of the sram-like req/addr_ok/data_ok handshake: in-order outstanding
// queue in front of a word-addressed memory, fixed-latency responses, stall throttle.
module sram_like_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        addr_stall
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [PW:0] FULL     = (PW + 1)'(DEPTH);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       mem_word;

    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              q_wr    [DEPTH];
    logic [31:0]       q_rdata [DEPTH];
    logic [3:0]        q_cnt   [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     off;

    logic accept, head_pop, bypass, push;
    logic unused_bits;

    assign idx         = addr[ADDR_W+1:2];
    assign mem_word    = mem[idx];
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    always_comb begin
        addr_ok  = ~addr_stall & (count != FULL);
        accept   = req & addr_ok & resetn;
        // Head is released at the edge where its countdown would reach zero, so a
        // request accepted at edge k responds at edge k+LATENCY-1; LATENCY=1 with an
        // empty queue answers straight from memory at the accept edge.
        head_pop = (count != '0) && (q_cnt[head] <= 4'd1);
        bypass   = accept && (count == '0) && (LATENCY == 1);
        push     = accept & ~bypass;
    end

    always_comb begin
        valid = '0;
        off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head;
            valid[i] = ({1'b0, off} < count);
        end
    end

    // Memory is deliberately not reset: writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_wr[i]    <= 1'b0;
                q_rdata[i] <= '0;
                q_cnt[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid[i] && (q_cnt[i] != 4'd0)) q_cnt[i] <= q_cnt[i] - 4'd1;
            end

            if (push) begin
                q_wr[tail]    <= wr;
                q_rdata[tail] <= mem_word;
                q_cnt[tail]   <= CNT_INIT;
                tail          <= tail + 1'b1;
            end

            if (head_pop) begin
                head    <= head + 1'b1;
                data_ok <= 1'b1;
                rdata   <= q_wr[head] ? 32'h0 : q_rdata[head];
            end else if (bypass) begin
                data_ok <= 1'b1;
                rdata   <= wr ? 32'h0 : mem_word;
            end else begin
                data_ok <= 1'b0;
            end

            case ({push, head_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: three instances with different latency/depth share one
// random request stream; a transaction-level model predicts addr_ok, data_ok and rdata.
module tb_sram_like_responder;

    logic        clk;
    logic        resetn;
    logic        req, wr, addr_stall;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [2:0]  aok, dok;
    logic [31:0] rd [3];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int          d;
        int          r;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] mmem [3][64];
    int          last_r [3];
    logic [31:0] last_rd [3];
    int          edge_n;

    sram_like_responder #(.ADDR_W(6), .LATENCY(2), .DEPTH(4)) u_d0 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]),
        .addr_stall(addr_stall));

    sram_like_responder #(.ADDR_W(6), .LATENCY(5), .DEPTH(4)) u_d1 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]),
        .addr_stall(addr_stall));

    sram_like_responder #(.ADDR_W(6), .LATENCY(1), .DEPTH(8)) u_d2 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]),
        .addr_stall(addr_stall));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 5 : 1;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic int qcount(input int d);
        int n = 0;
        foreach (rq[k]) if (rq[k].d == d) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Retire the responses due at the edge just taken and compare the port.
    task automatic check_responses();
        for (int d = 0; d < 3; d++) begin
            logic exp_dok;
            exp_dok = 1'b0;
            for (int k = 0; k < rq.size(); k++) begin
                if (rq[k].d == d) begin
                    if (rq[k].r == edge_n) begin
                        exp_dok    = 1'b1;
                        last_rd[d] = rq[k].data;
                        rq.delete(k);
                    end
                    break;
                end
            end
            check($sformatf("data_ok[%0d]", d), {31'b0, dok[d]}, {31'b0, exp_dok});
            check($sformatf("rdata[%0d]", d), rd[d], last_rd[d]);
        end
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic drive_cycle(input logic r, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic st, output logic [2:0] acc);
        logic [2:0]  exp_ok;
        logic [5:0]  ix;
        logic [31:0] dat;
        int          rt;
        rsp_t        e;
        req = r; wr = w; wstrb = s; addr = a; wdata = wd; addr_stall = st;
        size = 2'($urandom_range(0, 2));
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_ok[d] = !st && (qcount(d) < dep_of(d));
            check($sformatf("addr_ok[%0d]", d), {31'b0, aok[d]}, {31'b0, exp_ok[d]});
        end
        @(posedge clk);
        edge_n++;
        acc = '0;
        for (int d = 0; d < 3; d++) begin
            if (r && exp_ok[d]) begin
                acc[d] = 1'b1;
                ix     = a[7:2];
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mmem[d][ix][8*b +: 8] = wd[8*b +: 8];
                    dat = '0;
                end else begin
                    dat = mmem[d][ix];
                end
                rt = edge_n + lat_of(d) - 1;
                if (rt < last_r[d] + 1) rt = last_r[d] + 1;
                last_r[d] = rt;
                e.d = d; e.r = rt; e.data = dat;
                rq.push_back(e);
            end
        end
        @(negedge clk);
        check_responses();
    endtask

    task automatic idle_drain();
        logic [2:0] acc;
        for (int i = 0; i < 40 && rq.size() != 0; i++)
            drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
        check("drain_timeout", 32'(rq.size()), 32'd0);
    endtask

    // Present one request until every instance has taken it (repeats are harmless).
    task automatic until_all(input logic w, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] wd, input string tag);
        logic [2:0] acc, done;
        done = '0;
        for (int t = 0; t < 30 && done != 3'b111; t++) begin
            drive_cycle(1'b1, w, s, a, wd, 1'b0, acc);
            done |= acc;
        end
        check(tag, {29'b0, done}, 32'h7);
    endtask

    initial begin
        logic [2:0]  acc;
        logic [31:0] a;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; wstrb = '0; size = '0;
        addr = '0; wdata = '0; addr_stall = 1'b0;
        edge_n = 0;
        for (int d = 0; d < 3; d++) begin
            last_r[d] = 0; last_rd[d] = '0;
            for (int i = 0; i < 64; i++) mmem[d][i] = '0;
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_data_ok[%0d]", d), {31'b0, dok[d]}, 32'h0);
            check($sformatf("rst_rdata[%0d]", d), rd[d], 32'h0);
            check($sformatf("rst_addr_ok[%0d]", d), {31'b0, aok[d]}, 32'h1);
        end
        resetn = 1'b1;

        // Fill every word with known data through the port.
        for (int i = 0; i < 64; i++) begin
            a = {$urandom} & 32'hFFFF_FF00;
            a[7:2] = 6'(i);
            until_all(1'b1, 4'hF, a, (i == 16) ? 32'h1122_3344 : $urandom, "preload_accept");
        end
        idle_drain();

        drive_cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, acc);
        idle_drain();

        drive_cycle(1'b1, 1'b1, 4'b0101, 32'h40, 32'hAABB_CCDD, 1'b0, acc);
        drive_cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, acc);
        idle_drain();
        check("merged_word_model", mmem[0][16], 32'h11BB_33DD);

        for (int k = 0; k < 6; k++)
            until_all(1'b0, 4'h0, 32'h80 + 32'(4 * k), 32'h0, "burst_accept");
        idle_drain();

        repeat (5) drive_cycle(1'b1, 1'b1, 4'hF, 32'h44, 32'hDEAD_BEEF, 1'b1, acc);
        drive_cycle(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0, acc);
        check("stall_release_accept", {29'b0, acc}, 32'h7);
        idle_drain();

        // Asynchronous reset with reads still outstanding.
        drive_cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, acc);
        drive_cycle(1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0, acc);
        req = 1'b0;
        #2 resetn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("mid_rst_data_ok[%0d]", d), {31'b0, dok[d]}, 32'h0);
            check($sformatf("mid_rst_rdata[%0d]", d), rd[d], 32'h0);
            check($sformatf("mid_rst_addr_ok[%0d]", d), {31'b0, aok[d]}, 32'h1);
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        resetn = 1'b1;
        rq.delete();
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = '0;
            last_r[d]  = edge_n;
        end
        repeat (6) drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);

        for (int k = 0; k < 8; k++)
            drive_cycle(1'b1, 1'b0, 4'h0, 32'(4 * k), 32'h0, 1'b0, acc);
        idle_drain();

        for (int n = 0; n < 800; n++) begin
            drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                        4'($urandom), $urandom, $urandom,
                        $urandom_range(0, 9) < 2, acc);
        end
        idle_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
